// File: rtl/dmem_pkg.sv
// Shared types for the data-memory interface: access width and latched request payload.
package dmem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_width_e;

    typedef struct packed {
        logic [31:0] addr;
        mem_width_e  width;
        logic        sign_ext;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
    } dmem_req_t;

endpackage

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state insertion, lane steering, extension and fault reporting.
// Optional misalignment faulting is compiled in with `define DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_rd,
    input  logic        dmem_wr,
    input  mem_width_e  dmem_width,
    input  logic        dmem_sign_ext,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        dmem_fault
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam int unsigned CW   = 4;
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    dmem_req_t       req_q, req_d;
    dmem_req_t       req_in;
    dmem_req_t       act;
    logic            req;
    logic            ready_c;
    logic            fault_c;

    logic [31:0]     off;
    logic            in_range;
    logic            misaligned;
    logic [1:0]      lo;
    logic [AW-1:0]   idx;
    logic            we_d;
    logic [3:0]      be_d;
    logic [31:0]     wdata_d;
    logic [31:0]     word_r;
    logic [7:0]      byte_r;
    logic [15:0]     half_r;
    logic [31:0]     rd_ext;

    logic [31:0]     mem_q [DEPTH_WORDS];

    always_comb begin
        req    = dmem_rd | dmem_wr;
        req_in = '{addr: dmem_addr, width: dmem_width, sign_ext: dmem_sign_ext,
                   wdata: dmem_wdata, rd: dmem_rd, wr: dmem_wr};
    end

    // Next-state: accept in IDLE, count down in WAIT, abort on a dropped request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            S_IDLE: begin
                if (req && (WAIT_STATES != 0)) begin
                    req_d   = req_in;
                    cnt_d   = CW'(WAIT_STATES - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Zero wait states serve the live request; otherwise the latched copy
    always_comb begin
        if (WAIT_STATES == 0) begin
            act     = req_in;
            ready_c = req;
        end else begin
            act     = req_q;
            ready_c = (state_q == S_WAIT) && (cnt_q == '0) && req;
        end
        ready_c = ready_c & rst_n;
    end

    always_comb begin
        off      = act.addr - BASE_ADDR;
        in_range = off < SPAN;
        idx      = off[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
        lo         = act.addr[1:0];
        misaligned = ((act.width == MEM_HALF) && act.addr[0]) ||
                     ((act.width == MEM_WORD) && (act.addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
        unique case (act.width)
            MEM_BYTE: lo = act.addr[1:0];
            MEM_HALF: lo = {act.addr[1], 1'b0};
            default:  lo = 2'b00;
        endcase
`endif
        fault_c = ready_c && (!in_range || misaligned || (act.rd && act.wr));
        we_d    = ready_c && act.wr && in_range && !misaligned;
    end

    // Store lane steering
    always_comb begin
        be_d    = 4'hF;
        wdata_d = act.wdata;
        unique case (act.width)
            MEM_BYTE: begin
                be_d    = 4'b0001 << lo;
                wdata_d = {4{act.wdata[7:0]}};
            end
            MEM_HALF: begin
                be_d    = lo[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{act.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be_d[i]) mem_q[idx][8*i +: 8] <= wdata_d[8*i +: 8];
            end
        end
    end

    // Load lane extraction and extension
    always_comb begin
        word_r = mem_q[idx];
        byte_r = word_r[{lo, 3'b000} +: 8];
        half_r = word_r[{lo[1], 4'b0000} +: 16];
        unique case (act.width)
            MEM_BYTE: rd_ext = {{24{act.sign_ext & byte_r[7]}}, byte_r};
            MEM_HALF: rd_ext = {{16{act.sign_ext & half_r[15]}}, half_r};
            default:  rd_ext = word_r;
        endcase
    end

    always_comb begin
        dmem_ready = ready_c;
        dmem_fault = fault_c;
        dmem_rdata = (ready_c && !fault_c && act.rd) ? rd_ext : '0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (1, 3 and 0 wait states) against a memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int          NI    = 3;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    typedef struct {
        int          due;
        bit          is_load;
        logic [31:0] rdata;
        bit          fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_s    [NI];
    logic        wr_s    [NI];
    logic        sext_s  [NI];
    logic [31:0] addr_s  [NI];
    logic [31:0] wdata_s [NI];
    mem_width_e  width_s [NI];
    logic [31:0] rdata_s [NI];
    logic        ready_s [NI];
    logic        fault_s [NI];

    logic [31:0] model [NI][DEPTH];
    exp_t        sb_q  [NI][$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          final_chk = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .BASE_ADDR  (BASE),
            .WAIT_STATES(WS)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .dmem_addr    (addr_s[g]),
            .dmem_rd      (rd_s[g]),
            .dmem_wr      (wr_s[g]),
            .dmem_width   (width_s[g]),
            .dmem_sign_ext(sext_s[g]),
            .dmem_wdata   (wdata_s[g]),
            .dmem_rdata   (rdata_s[g]),
            .dmem_ready   (ready_s[g]),
            .dmem_fault   (fault_s[g])
        );
    end

    function automatic int unsigned ws_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
    endfunction

    function automatic int nbytes(mem_width_e w);
        return (w == MEM_BYTE) ? 1 : ((w == MEM_HALF) ? 2 : 4);
    endfunction

    function automatic bit in_rng(logic [31:0] a);
        return (a >= BASE) && (a < BASE + DEPTH * 4);
    endfunction

    function automatic bit misal(mem_width_e w, logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a % nbytes(w)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] eff_addr(mem_width_e w, logic [31:0] a);
        return a - (a % nbytes(w));
    endfunction

    function automatic logic [31:0] model_read(int i, mem_width_e w, bit sext, logic [31:0] a);
        logic [31:0] e;
        logic [31:0] v;
        int          nb;
        e  = eff_addr(w, a);
        nb = nbytes(w);
        v  = model[i][(e - BASE) / 4] >> (8 * (e % 4));
        if (nb == 1) begin
            v = v % 32'h100;
            if (sext && v >= 32'h80) v = v - 32'h100;
        end else if (nb == 2) begin
            v = v % 32'h1_0000;
            if (sext && v >= 32'h8000) v = v - 32'h1_0000;
        end
        return v;
    endfunction

    task automatic model_write(int i, mem_width_e w, logic [31:0] a, logic [31:0] wd);
        logic [31:0] e;
        logic [31:0] mask;
        int          nb;
        int          sh;
        e    = eff_addr(w, a);
        nb   = nbytes(w);
        sh   = 8 * int'(e % 4);
        mask = (nb == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * nb)) - 32'h1) << sh);
        model[i][(e - BASE) / 4] = (model[i][(e - BASE) / 4] & ~mask) | ((wd << sh) & mask);
    endtask

    // Present one access in the next cycle and hold it until its ready cycle
    task automatic access(int i, bit rd, bit wr, mem_width_e w, bit sext,
                          logic [31:0] a, logic [31:0] wd);
        exp_t e;
        bit   bad;
        bad       = !in_rng(a) || misal(w, a);
        e.fault   = bad || (rd && wr);
        e.is_load = rd && !wr;
        e.rdata   = (e.fault || !e.is_load) ? 32'h0 : model_read(i, w, sext, a);
        @(posedge clk); #1;
        rd_s[i]    = rd;
        wr_s[i]    = wr;
        width_s[i] = w;
        sext_s[i]  = sext;
        addr_s[i]  = a;
        wdata_s[i] = wd;
        e.due      = cyc + int'(ws_of(i));
        sb_q[i].push_back(e);
        if (wr && !rd && !bad) model_write(i, w, a, wd);
        repeat (ws_of(i)) begin @(posedge clk); #1; end
    endtask

    task automatic idle(int i);
        @(posedge clk); #1;
        rd_s[i] = 1'b0;
        wr_s[i] = 1'b0;
    endtask

    // Scoreboard monitor for all instances
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                n_tests++;
                if (ready_s[i] !== 1'b0 || fault_s[i] !== 1'b0 || rdata_s[i] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_outputs inst%0d: ready=%b fault=%b rdata=%h, required 0 0 00000000",
                             i, ready_s[i], fault_s[i], rdata_s[i]);
                end
            end else if (ready_s[i] === 1'b1) begin
                n_tests++;
                if (sb_q[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_ready inst%0d cycle %0d: ready=1, required 0", i, cyc);
                end else begin
                    e = sb_q[i].pop_front();
                    if (cyc != e.due || fault_s[i] !== e.fault ||
                        ((e.is_load || e.fault) && rdata_s[i] !== e.rdata)) begin
                        n_fail++;
                        $display("FAIL access inst%0d: cycle=%0d fault=%b rdata=%h, required cycle=%0d fault=%b rdata=%h",
                                 i, cyc, fault_s[i], rdata_s[i], e.due, e.fault, e.rdata);
                    end
                end
            end else begin
                n_tests++;
                if (rdata_s[i] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL idle_rdata inst%0d cycle %0d: rdata=%h, required 00000000",
                             i, cyc, rdata_s[i]);
                end
                if (sb_q[i].size() != 0 && sb_q[i][0].due <= cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_ready inst%0d: ready=%b at cycle %0d, required 1",
                             i, ready_s[i], cyc);
                    void'(sb_q[i].pop_front());
                end
            end
            if (final_chk) begin
                n_tests++;
                if (sb_q[i].size() != 0) begin
                    n_fail++;
                    $display("FAIL drain inst%0d: %0d accesses outstanding, required 0", i, sb_q[i].size());
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        mem_width_e  w;
        bit          op;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            rd_s[i] = 1'b1; wr_s[i] = 1'b0; sext_s[i] = 1'b0;
            addr_s[i] = BASE; wdata_s[i] = 32'h0; width_s[i] = MEM_WORD;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rd_s[i] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fill every instance so the model knows the whole array
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < int'(DEPTH); k++)
                access(i, 1'b0, 1'b1, MEM_WORD, 1'b0, BASE + 32'(4 * k), $urandom);
            idle(i);
        end

        // Directed loads/stores, extension, lane write and faults on 1 wait state
        access(0, 0, 1, MEM_WORD, 0, 32'h1000_0010, 32'hDEAD_BEEF);
        access(0, 1, 0, MEM_WORD, 0, 32'h1000_0010, 32'h0);
        access(0, 0, 1, MEM_WORD, 0, 32'h1000_0020, 32'h80FF_7F01);
        access(0, 1, 0, MEM_BYTE, 1, 32'h1000_0023, 32'h0);
        access(0, 1, 0, MEM_BYTE, 0, 32'h1000_0023, 32'h0);
        access(0, 1, 0, MEM_HALF, 1, 32'h1000_0022, 32'h0);
        access(0, 1, 0, MEM_HALF, 0, 32'h1000_0020, 32'h0);
        access(0, 0, 1, MEM_WORD, 0, 32'h1000_0020, 32'h0);
        access(0, 0, 1, MEM_BYTE, 0, 32'h1000_0021, 32'h0000_00AA);
        access(0, 1, 0, MEM_WORD, 0, 32'h1000_0020, 32'h0);
        access(0, 1, 0, MEM_WORD, 0, 32'h2000_0000, 32'h0);
        access(0, 0, 1, MEM_WORD, 0, 32'h1000_0002, 32'h1357_9BDF);
        access(0, 1, 0, MEM_WORD, 0, 32'h1000_0000, 32'h0);
        access(0, 1, 0, MEM_WORD, 0, BASE + 32'(DEPTH * 4 - 4), 32'h0);
        access(0, 1, 0, MEM_BYTE, 0, BASE + 32'(DEPTH * 4), 32'h0);
        access(0, 1, 0, MEM_WORD, 0, BASE - 32'h4, 32'h0);
        access(0, 1, 1, MEM_WORD, 0, BASE + 32'd252, 32'h1234_5678);
        access(0, 0, 1, MEM_WORD, 0, BASE + 32'd252, 32'h0BAD_F00D);
        idle(0);

        // Abort mid-WAIT on 3 wait states: no ready, word unchanged
        @(posedge clk); #1;
        rd_s[1] = 1'b0; wr_s[1] = 1'b1; width_s[1] = MEM_WORD;
        addr_s[1] = BASE + 32'h30; wdata_s[1] = ~model[1][12];
        @(posedge clk); #1;
        wr_s[1] = 1'b0;
        repeat (4) @(posedge clk);
        access(1, 1, 0, MEM_WORD, 0, BASE + 32'h30, 32'h0);
        idle(1);

        // Zero wait states: four stores then four loads back to back
        for (int k = 0; k < 4; k++)
            access(2, 0, 1, MEM_WORD, 0, BASE + 32'(8 * k), $urandom);
        for (int k = 0; k < 4; k++)
            access(2, 1, 0, MEM_WORD, 0, BASE + 32'(8 * k), 32'h0);
        idle(2);

        // Randomized mix on every instance
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 120; n++) begin
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       a = BASE + 32'(DEPTH * 4) + $urandom_range(0, 255);
                        1:       a = BASE - 32'h1 - $urandom_range(0, 255);
                        default: a = 32'h2000_0000;
                    endcase
                end else begin
                    a = BASE + $urandom_range(0, DEPTH * 4 - 1);
                end
                w  = mem_width_e'(2'($urandom_range(0, 2)));
                op = 1'($urandom_range(0, 1));
                access(i, op, !op, w, 1'($urandom_range(0, 1)), a, $urandom);
                if ($urandom_range(0, 3) == 0) idle(i);
            end
            idle(i);
        end

        // Reset during WAIT discards the pending store
        @(posedge clk); #1;
        rd_s[1] = 1'b0; wr_s[1] = 1'b1; width_s[1] = MEM_WORD;
        addr_s[1] = BASE + 32'h40; wdata_s[1] = ~model[1][16];
        @(posedge clk); #1;
        rst_n   = 1'b0;
        wr_s[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(1, 1, 0, MEM_WORD, 0, BASE + 32'h40, 32'h0);
        idle(1);

        repeat (6) @(posedge clk);
        #1;
        final_chk = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
